serial_mag_cmp: RTL and testbench

//   Multi-cycle magnitude comparator controller for two WIDTH-bit unsigned operands.

---
 rtl/serial_mag_cmp.sv | 150 +++++++++++++++
 tb/tb_serial_mag_cmp.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_mag_cmp.sv
// ---------------------------------------------------------------------------
// serial_mag_cmp
//   Multi-cycle magnitude comparator for two WIDTH-bit unsigned operands.
//   The operands are captured on start. They are then walked MSB-first, one
//   2-bit slice per clock. The most significant unequal slice decides the
//   result. With EARLY_EXIT=1 the walk stops at the first unequal slice.
//   With EARLY_EXIT=0 all slices are always scanned.
//
// Parameters
//   WIDTH       operand width, even and >= 2 (NSLICE = WIDTH/2)
//   EARLY_EXIT  1: finish at first unequal slice, 0: fixed-latency full scan
//
// Ports
//   clk    in   system clock, rising edge
//   reset  in   synchronous active-high reset
//   start  in   request, sampled only while busy=0
//   a, b   in   operands, captured in the cycle start is accepted
//   busy   out  high in RUN and DONE
//   done   out  one-cycle pulse, results valid from this cycle
//   gt     out  a > b
//   eq     out  a == b
//   lt     out  a < b
// ---------------------------------------------------------------------------
module serial_mag_cmp #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int NSLICE = WIDTH / 2;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             diff_q, diff_d;   // an unequal slice has been seen
  logic             gti_q, gti_d;     // that first unequal slice had a > b
  logic             gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;

  logic [1:0]       sa, sb;
  logic             slice_ne;

  // The current slice pair, selected by the walking index.
  assign sa       = a_q[{idx_q, 1'b0} +: 2];
  assign sb       = b_q[{idx_q, 1'b0} +: 2];
  assign slice_ne = (sa != sb);

  always_comb begin
    // NOTE: every variable gets a default before the case statement. Without
    // it, a path that leaves one unassigned would infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    gti_d   = gti_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          a_d     = a;
          b_d     = b;
          idx_d   = IDX_W'(NSLICE - 1);
          diff_d  = 1'b0;
          gti_d   = 1'b0;
          gt_d    = 1'b0;
          eq_d    = 1'b0;
          lt_d    = 1'b0;
        end
      end

      S_RUN: begin
        // Only the first unequal slice is recorded. Later slices cannot
        // override it, even during a full scan.
        if (slice_ne && !diff_q) begin
          diff_d = 1'b1;
          gti_d  = (sa > sb);
        end
        if ((EARLY_EXIT && slice_ne) || (idx_q == '0)) begin
          state_d = S_DONE;
          // Results are loaded on entry to DONE so that they are valid
          // together with the done pulse.
          gt_d    = diff_d & gti_d;
          lt_d    = diff_d & ~gti_d;
          eq_d    = ~diff_d;
        end else begin
          idx_d   = idx_q - IDX_W'(1);
        end
      end

      S_DONE:  state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. This keeps
  // every flop sampling the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      diff_q  <= 1'b0;
      gti_q   <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      diff_q  <= diff_d;
      gti_q   <= gti_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
    end
  end

  // NOTE: the operand registers are deliberately left out of reset. They are
  // always loaded before they are read, so a reset would only add fan-out.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign gt   = gt_q;
  assign eq   = eq_q;
  assign lt   = lt_q;

endmodule

// File: tb/tb_serial_mag_cmp.sv
// ---------------------------------------------------------------------------
// tb_serial_mag_cmp
//   Directed bench for serial_mag_cmp. It uses three instances:
//     d=0 : WIDTH=8, EARLY_EXIT=1
//     d=1 : WIDTH=8, EARLY_EXIT=0
//     d=2 : WIDTH=2, EARLY_EXIT=1
//   Cycle 0 is the cycle in which start is presented to an idle DUT. Inputs
//   change and outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_serial_mag_cmp;

  logic       clk = 1'b0;
  logic       reset;
  logic       st  [3];
  logic [7:0] av  [3];
  logic [7:0] bv  [3];
  logic       bsy [3];
  logic       dn  [3];
  logic       g   [3];
  logic       e   [3];
  logic       l   [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_mag_cmp #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut_ee (
    .clk(clk), .reset(reset), .start(st[0]), .a(av[0]), .b(bv[0]),
    .busy(bsy[0]), .done(dn[0]), .gt(g[0]), .eq(e[0]), .lt(l[0]));

  serial_mag_cmp #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut_full (
    .clk(clk), .reset(reset), .start(st[1]), .a(av[1]), .b(bv[1]),
    .busy(bsy[1]), .done(dn[1]), .gt(g[1]), .eq(e[1]), .lt(l[1]));

  serial_mag_cmp #(.WIDTH(2), .EARLY_EXIT(1'b1)) dut_w2 (
    .clk(clk), .reset(reset), .start(st[2]), .a(av[2][1:0]), .b(bv[2][1:0]),
    .busy(bsy[2]), .done(dn[2]), .gt(g[2]), .eq(e[2]), .lt(l[2]));

  // Result encoding used by the expected values below: {gt, eq, lt}.
  localparam logic [2:0] R_GT = 3'b100;
  localparam logic [2:0] R_EQ = 3'b010;
  localparam logic [2:0] R_LT = 3'b001;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation on DUT d and checks three things: the done cycle,
  // the result, and the post-done return to idle with the results held.
  // With wiggle set, the task also changes the operands and pulses start
  // during RUN and DONE. Both must be ignored.
  task automatic run_op(input int d, input logic [7:0] a_in, input logic [7:0] b_in,
                        input int exp_cyc, input logic [2:0] exp_r,
                        input string name, input bit wiggle);
    int cyc;
    bit seen;
    cyc  = 0;
    seen = 1'b0;
    st[d] = 1'b1;
    av[d] = a_in;
    bv[d] = b_in;
    while (!seen && cyc < 40) begin
      tick();
      cyc++;
      st[d] = 1'b0;
      if (cyc == 1) begin
        checks++;
        if ({bsy[d], g[d], e[d], l[d]} !== 4'b1000) begin
          failures++;
          $display("FAIL %s_cycle1: busy/gt/eq/lt=%b required 1000", name,
                   {bsy[d], g[d], e[d], l[d]});
        end
      end
      if (dn[d] === 1'b1) seen = 1'b1;
      if (!seen && wiggle && (cyc == 1 || cyc == 3)) begin
        st[d] = 1'b1;
        av[d] = ~a_in;
        bv[d] = a_in ^ 8'h5A;
      end
    end
    checks++;
    if (!seen || cyc != exp_cyc) begin
      failures++;
      $display("FAIL %s_latency: done seen=%0d in cycle %0d, required cycle %0d",
               name, seen, cyc, exp_cyc);
    end
    checks++;
    if ({g[d], e[d], l[d]} !== exp_r) begin
      failures++;
      $display("FAIL %s_result: gt/eq/lt=%b required %b", name, {g[d], e[d], l[d]}, exp_r);
    end
    if (wiggle) begin
      st[d] = 1'b1;
      av[d] = 8'h00;
      bv[d] = 8'hFF;
    end
    tick();
    st[d] = 1'b0;
    checks++;
    if ({bsy[d], dn[d], g[d], e[d], l[d]} !== {2'b00, exp_r}) begin
      failures++;
      $display("FAIL %s_after: busy/done/gt/eq/lt=%b required %b", name,
               {bsy[d], dn[d], g[d], e[d], l[d]}, {2'b00, exp_r});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0;
      av[i] = 8'h00;
      bv[i] = 8'h00;
    end
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bsy[i], dn[i], g[i], e[i], l[i]} !== 5'b00000) begin
        failures++;
        $display("FAIL reset_dut%0d: busy/done/gt/eq/lt=%b required 00000", i,
                 {bsy[i], dn[i], g[i], e[i], l[i]});
      end
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_equal();
    run_op(0, 8'hA5, 8'hA5, 5, R_EQ, "eq_A5", 1'b0);
  endtask

  task automatic test_early_exit();
    run_op(0, 8'hC0, 8'h80, 2, R_GT, "ee_msb_gt", 1'b0);
    run_op(0, 8'h7F, 8'hBF, 2, R_LT, "ee_msb_lt", 1'b0);
    run_op(0, 8'hFF, 8'hF0, 4, R_GT, "ee_k3_gt", 1'b0);
    run_op(0, 8'h01, 8'h03, 5, R_LT, "ee_lsb_lt", 1'b0);
  endtask

  task automatic test_full_scan();
    run_op(1, 8'h40, 8'h3F, 5, R_GT, "full_40_3F", 1'b0);
    run_op(1, 8'h80, 8'hFF, 5, R_LT, "full_80_FF", 1'b0);
    run_op(1, 8'h5A, 8'h5A, 5, R_EQ, "full_eq", 1'b0);
  endtask

  task automatic test_operand_hold();
    run_op(0, 8'h12, 8'h13, 5, R_LT, "hold_12_13", 1'b1);
    run_op(1, 8'hC3, 8'h3C, 5, R_GT, "hold_full", 1'b1);
  endtask

  task automatic test_width2();
    run_op(2, 8'h02, 8'h01, 2, R_GT, "w2_gt", 1'b0);
    run_op(2, 8'h01, 8'h01, 2, R_EQ, "w2_eq", 1'b0);
    run_op(2, 8'h00, 8'h03, 2, R_LT, "w2_lt", 1'b0);
  endtask

  task automatic test_back_to_back();
    int done_cycles[$];
    int bad_res;
    bad_res = 0;
    st[0] = 1'b1;
    av[0] = 8'h3C;
    bv[0] = 8'h3C;
    for (int cyc = 1; cyc <= 17; cyc++) begin
      tick();
      if (dn[0] === 1'b1) begin
        done_cycles.push_back(cyc);
        if ({g[0], e[0], l[0]} !== R_EQ) bad_res++;
      end
      if (cyc == 17) st[0] = 1'b0;
    end
    checks++;
    if (done_cycles.size() != 3 || done_cycles[0] != 5 || done_cycles[1] != 11 ||
        done_cycles[2] != 17) begin
      failures++;
      $display("FAIL b2b_done_cycles: got %p required '{5, 11, 17}", done_cycles);
    end
    checks++;
    if (bad_res != 0) begin
      failures++;
      $display("FAIL b2b_result: %0d done pulses without eq=1, required 0", bad_res);
    end
    tick();
    checks++;
    if (bsy[0] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle: busy=%b required 0", bsy[0]);
    end
  endtask

  task automatic test_reset_abort();
    int stray;
    stray = 0;
    st[0] = 1'b1;
    av[0] = 8'h55;
    bv[0] = 8'h55;
    tick();
    st[0] = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({bsy[0], dn[0], g[0], e[0], l[0]} !== 5'b00000) begin
      failures++;
      $display("FAIL abort_clear: busy/done/gt/eq/lt=%b required 00000",
               {bsy[0], dn[0], g[0], e[0], l[0]});
    end
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (dn[0] !== 1'b0 || bsy[0] !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL abort_quiet: %0d cycles with done/busy set, required 0", stray);
    end
    run_op(0, 8'h55, 8'h55, 5, R_EQ, "abort_restart", 1'b0);
  endtask

  initial begin
    test_reset();
    test_equal();
    test_early_exit();
    test_full_scan();
    test_operand_hold();
    test_width2();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
